// File: rtl/hdmi_video_if.sv
// Parallel video bus between the timing generator, the pixel source
// and the ADV7513 transmitter.
interface hdmi_video_if;
  logic        pix_req;
  logic [11:0] pix_x;
  logic [10:0] pix_y;
  logic        frame_start;
  logic [23:0] rgb_in;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [23:0] rgb_out;

  modport master (
    output pix_req, pix_x, pix_y, frame_start,
    output hsync, vsync, de, rgb_out,
    input  rgb_in
  );

  modport slave (
    input  pix_req, pix_x, pix_y, frame_start,
    input  hsync, vsync, de, rgb_out,
    output rgb_in
  );
endinterface

// File: rtl/hdmi_video_timing.sv
// ADV7513 video timing generator with coordinate-based pixel requests.
// Optional colour bars: define HDMI_TEST_PATTERN_EN.
module hdmi_video_timing #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic pattern_sel,
  output logic active,
  hdmi_video_if.master vid
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_A    = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST = 12'(H_TOT - 1);
  localparam logic [11:0] HS_B   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_E   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_A    = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST = 11'(V_TOT - 1);
  localparam logic [10:0] VS_B   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_E   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic HS_P = (HS_POL != 0);
  localparam logic VS_P = (VS_POL != 0);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state;
  logic [11:0] h;
  logic [10:0] v;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      h     <= '0;
      v     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en) begin
            state <= RUN;
            h     <= '0;
            v     <= '0;
          end
        end
        RUN: begin
          if (h == H_LAST) begin
            h <= '0;
            if (v == V_LAST) begin
              v <= '0;
              if (!en) state <= IDLE;
            end else begin
              v <= v + 11'd1;
            end
          end else begin
            h <= h + 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign active = (state == RUN);

  logic in_act;
  logic hs_c;
  logic vs_c;
  assign in_act = active && (h < H_A) && (v < V_A);
  assign hs_c   = active && (h >= HS_B) && (h < HS_E);
  assign vs_c   = active && (v >= VS_B) && (v < VS_E);

  // Sync flags ride one stage behind the request, next to de
  logic hs_n;
  logic vs_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      vid.pix_req     <= 1'b0;
      vid.pix_x       <= '0;
      vid.pix_y       <= '0;
      vid.frame_start <= 1'b0;
      hs_n            <= 1'b0;
      vs_n            <= 1'b0;
    end else begin
      vid.pix_req     <= in_act;
      vid.pix_x       <= in_act ? h : '0;
      vid.pix_y       <= in_act ? v : '0;
      vid.frame_start <= active && (h == '0) && (v == '0);
      hs_n            <= hs_c;
      vs_n            <= vs_c;
    end
  end

  logic [23:0] rgb_sel;

`ifdef HDMI_TEST_PATTERN_EN
  localparam int BW = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [2:0]  bar;
  logic [23:0] bar_rgb;

  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++)
      if (vid.pix_x >= 12'(k * BW)) bar = 3'(k);
  end

  always_comb begin
    bar_rgb = 24'h000000;
    unique case (bar)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      3'd7: bar_rgb = 24'h000000;
      default: bar_rgb = 24'h000000;
    endcase
  end

  assign rgb_sel = pattern_sel ? bar_rgb : vid.rgb_in;
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign rgb_sel = vid.rgb_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      vid.de      <= 1'b0;
      vid.rgb_out <= '0;
      vid.hsync   <= ~HS_P;
      vid.vsync   <= ~VS_P;
    end else begin
      vid.de      <= vid.pix_req;
      vid.rgb_out <= vid.pix_req ? rgb_sel : '0;
      vid.hsync   <= hs_n ~^ HS_P;
      vid.vsync   <= vs_n ~^ VS_P;
    end
  end
endmodule
